// File: rtl/nic_tx_pkg.sv
// Shared NIC transmit pipe definitions: word layout constants and arbiter state encoding.
package nic_tx_pkg;

  localparam int MAC_WIDTH   = 64;
  localparam int TKEEP_WIDTH = 8;
  localparam int NIC_WIDTH   = MAC_WIDTH + TKEEP_WIDTH + 1;
  localparam int LAST_BIT    = NIC_WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_t;

  function automatic logic word_last(input logic [NIC_WIDTH-1:0] w);
    return w[LAST_BIT];
  endfunction

endpackage

// File: rtl/mac_tx_frame_arbiter_if.sv
// Pipe bundle between the two NIC TX sources, the frame arbiter and the TX_FIFO pipe.
interface mac_tx_frame_arbiter_if;
  import nic_tx_pkg::*;

  // Every pipe moves one word on a cycle where req and ack are both high; the producer
  // holds req and data until that cycle, and ack may depend combinationally on state.
  logic [NIC_WIDTH-1:0] src0_pipe_write_data;
  logic                 src0_pipe_write_req;
  logic                 src0_pipe_write_ack;
  logic [NIC_WIDTH-1:0] src1_pipe_write_data;
  logic                 src1_pipe_write_req;
  logic                 src1_pipe_write_ack;
  logic [NIC_WIDTH-1:0] TX_FIFO_pipe_write_data;
  logic                 TX_FIFO_pipe_write_req;
  logic                 TX_FIFO_pipe_write_ack;

  modport master (
    output src0_pipe_write_data, src0_pipe_write_req, input src0_pipe_write_ack,
    output src1_pipe_write_data, src1_pipe_write_req, input src1_pipe_write_ack,
    input  TX_FIFO_pipe_write_data, TX_FIFO_pipe_write_req, output TX_FIFO_pipe_write_ack
  );

  modport slave (
    input  src0_pipe_write_data, src0_pipe_write_req, output src0_pipe_write_ack,
    input  src1_pipe_write_data, src1_pipe_write_req, output src1_pipe_write_ack,
    output TX_FIFO_pipe_write_data, TX_FIFO_pipe_write_req, input TX_FIFO_pipe_write_ack
  );

endinterface

// File: rtl/nic_pipe_out_reg.sv
// One-entry output register for a NIC pipe; accepts a new word in the same cycle the held one leaves.
module nic_pipe_out_reg
  import nic_tx_pkg::*;
#(
  parameter int W = NIC_WIDTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_data,
  output logic         ready,
  output logic         out_req,
  output logic [W-1:0] out_data,
  input  logic         out_ack
);

  logic         valid_q;
  logic [W-1:0] data_q;

  assign ready    = !valid_q || out_ack;
  assign out_req  = valid_q;
  assign out_data = data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= load_data;
    end else if (out_ack) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/mac_tx_frame_arbiter.sv
// Frame-granular round-robin arbiter merging two NIC TX pipes into the TX_FIFO pipe.
// Defining TX_ARB_STATS_EN adds per-source completed-frame counters.
module mac_tx_frame_arbiter
  import nic_tx_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            src_enable,
  mac_tx_frame_arbiter_if.slave pipe,
  output logic                  busy,
  output logic                  grant_id,
`ifdef TX_ARB_STATS_EN
  output logic [31:0]           src0_frame_count,
  output logic [31:0]           src1_frame_count,
`endif
  output arb_state_t            state_dbg
);

  arb_state_t           state_q, state_d;
  logic                 grant_q, grant_d;
  logic                 rr_last_q;
  logic [1:0]           eligible;
  logic                 src0_ack, src1_ack;
  logic                 load, load_last;
  logic [NIC_WIDTH-1:0] load_data;
  logic                 ready;
  logic                 out_req;
  logic [NIC_WIDTH-1:0] out_data;

  assign eligible = {pipe.src1_pipe_write_req & src_enable[1],
                     pipe.src0_pipe_write_req & src_enable[0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= 1'b0;
      rr_last_q <= 1'b1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      if (load_last) rr_last_q <= grant_q;
    end
  end

  // Grant is chosen only from IDLE; enable and req changes mid-frame never drop it.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (eligible == 2'b11) begin
          grant_d = ~rr_last_q;
          state_d = rr_last_q ? GRANT0 : GRANT1;
        end else if (eligible[0]) begin
          grant_d = 1'b0;
          state_d = GRANT0;
        end else if (eligible[1]) begin
          grant_d = 1'b1;
          state_d = GRANT1;
        end
      end
      GRANT0, GRANT1: begin
        if (load_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    src0_ack  = 1'b0;
    src1_ack  = 1'b0;
    load      = 1'b0;
    load_data = pipe.src0_pipe_write_data;
    case (state_q)
      GRANT0: begin
        src0_ack  = ready;
        load      = pipe.src0_pipe_write_req && ready;
        load_data = pipe.src0_pipe_write_data;
      end
      GRANT1: begin
        src1_ack  = ready;
        load      = pipe.src1_pipe_write_req && ready;
        load_data = pipe.src1_pipe_write_data;
      end
      default: ;
    endcase
  end

  assign load_last = load && word_last(load_data);

  nic_pipe_out_reg #(.W(NIC_WIDTH)) u_out_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_data (load_data),
    .ready     (ready),
    .out_req   (out_req),
    .out_data  (out_data),
    .out_ack   (pipe.TX_FIFO_pipe_write_ack)
  );

  assign pipe.src0_pipe_write_ack     = src0_ack;
  assign pipe.src1_pipe_write_ack     = src1_ack;
  assign pipe.TX_FIFO_pipe_write_req  = out_req;
  assign pipe.TX_FIFO_pipe_write_data = out_data;

  assign busy      = (state_q != IDLE);
  assign grant_id  = grant_q;
  assign state_dbg = state_q;

`ifdef TX_ARB_STATS_EN
  logic [31:0] cnt0_q, cnt1_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (load_last) begin
      if (grant_q) cnt1_q <= cnt1_q + 32'd1;
      else         cnt0_q <= cnt0_q + 32'd1;
    end
  end

  assign src0_frame_count = cnt0_q;
  assign src1_frame_count = cnt1_q;
`endif

endmodule

// File: tb/tb_mac_tx_frame_arbiter.sv
// Directed bench for mac_tx_frame_arbiter: per-cycle vector table plus multi-cycle stall/enable/reset sequences.
module tb_mac_tx_frame_arbiter;
  import nic_tx_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] src_enable = 2'b11;
  logic       busy;
  logic       grant_id;
  arb_state_t state_dbg;
`ifdef TX_ARB_STATS_EN
  logic [31:0] cnt0, cnt1;
`endif

  mac_tx_frame_arbiter_if ifc ();

  mac_tx_frame_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .src_enable (src_enable),
    .pipe       (ifc.slave),
    .busy       (busy),
    .grant_id   (grant_id),
`ifdef TX_ARB_STATS_EN
    .src0_frame_count (cnt0),
    .src1_frame_count (cnt1),
`endif
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic sb_on = 1'b0;
  logic [NIC_WIDTH-1:0] exp_q[$];

  typedef struct {
    logic rst; logic chk; logic [1:0] en;
    logic s0_req; logic [NIC_WIDTH-1:0] s0_data;
    logic s1_req; logic [NIC_WIDTH-1:0] s1_data;
    logic tx_ack;
    logic e_s0_ack; logic e_s1_ack; logic e_tx_req; logic [NIC_WIDTH-1:0] e_tx_data;
    logic e_busy; logic e_grant;
  } vec_t;
  vec_t tbl[$];

  function automatic logic [NIC_WIDTH-1:0] wd(input logic last, input logic [63:0] v);
    return {last, v, 8'hFF};
  endfunction

  function automatic vec_t mkv(input logic rst, input logic chk, input logic [1:0] en,
      input logic s0r, input logic [NIC_WIDTH-1:0] s0d, input logic s1r, input logic [NIC_WIDTH-1:0] s1d,
      input logic txa, input logic es0, input logic es1, input logic etr,
      input logic [NIC_WIDTH-1:0] etd, input logic eb, input logic eg);
    vec_t v;
    v.rst = rst; v.chk = chk; v.en = en;
    v.s0_req = s0r; v.s0_data = s0d; v.s1_req = s1r; v.s1_data = s1d; v.tx_ack = txa;
    v.e_s0_ack = es0; v.e_s1_ack = es1; v.e_tx_req = etr; v.e_tx_data = etd;
    v.e_busy = eb; v.e_grant = eg;
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive_src(input int src, input logic req, input logic [NIC_WIDTH-1:0] d);
    if (src == 0) begin
      ifc.src0_pipe_write_req = req; ifc.src0_pipe_write_data = d;
    end else begin
      ifc.src1_pipe_write_req = req; ifc.src1_pipe_write_data = d;
    end
  endtask

  function automatic logic src_ack(input int src);
    return (src == 0) ? ifc.src0_pipe_write_ack : ifc.src1_pipe_write_ack;
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    drive_src(0, 1'b0, '0);
    drive_src(1, 1'b0, '0);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic send_frame(input int src, input int nwords, input logic [63:0] base);
    logic [NIC_WIDTH-1:0] d;
    int guard;
    for (int w = 0; w < nwords; w++) begin
      d = wd(w == nwords - 1, base + 64'(w));
      drive_src(src, 1'b1, d);
      guard = 0;
      forever begin
        @(negedge clk);
        if (src_ack(src)) begin
          exp_q.push_back(d);
          break;
        end
        guard++;
        if (guard > 100) begin
          checks++; failures++;
          $display("FAIL send_frame_timeout src=%0d word=%0d actual=no_ack required=ack", src, w);
          break;
        end
        @(posedge clk); #1;
      end
      @(posedge clk); #1;
    end
    drive_src(src, 1'b0, '0);
  endtask

  task automatic monitor();
    logic [NIC_WIDTH-1:0] e;
    forever begin
      @(negedge clk);
      if (sb_on && ifc.TX_FIFO_pipe_write_req && ifc.TX_FIFO_pipe_write_ack) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL sb_unexpected actual=%h required=none", ifc.TX_FIFO_pipe_write_data);
        end else begin
          e = exp_q.pop_front();
          check("sb_word", 128'(ifc.TX_FIFO_pipe_write_data), 128'(e));
        end
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NIC_WIDTH-1:0] z, held;
    logic [NIC_WIDTH-1:0] a1, a2, a3, a4, b1, b2, b3, b4, w41, w51;
    logic s1_seen;
    int n;

    z = '0;
    ifc.src0_pipe_write_req = 1'b0; ifc.src0_pipe_write_data = '0;
    ifc.src1_pipe_write_req = 1'b0; ifc.src1_pipe_write_data = '0;
    ifc.TX_FIFO_pipe_write_ack = 1'b0;
    fork monitor(); join_none

    // Single-source 3-word frame, TX_FIFO ack tied high.
    a1 = wd(0, 64'h11); a2 = wd(0, 64'h12); a3 = wd(1, 64'h13);
    tbl.push_back(mkv(1,0,2'b11, 0,z, 0,z, 1, 0,0,0,z, 0,0));
    tbl.push_back(mkv(0,1,2'b11, 0,z, 0,z, 1, 0,0,0,z, 0,0));
    tbl.push_back(mkv(0,1,2'b11, 1,a1, 0,z, 1, 0,0,0,z, 0,0));
    tbl.push_back(mkv(0,1,2'b11, 1,a1, 0,z, 1, 1,0,0,z, 1,0));
    tbl.push_back(mkv(0,1,2'b11, 1,a2, 0,z, 1, 1,0,1,a1, 1,0));
    tbl.push_back(mkv(0,1,2'b11, 1,a3, 0,z, 1, 1,0,1,a2, 1,0));
    tbl.push_back(mkv(0,1,2'b11, 0,z, 0,z, 1, 0,0,1,a3, 0,0));
    tbl.push_back(mkv(0,1,2'b11, 0,z, 0,z, 1, 0,0,0,a3, 0,0));
    // Both sources, 2-word frames, alternating grants with a bubble between frames.
    a1 = wd(0, 64'h21); a2 = wd(1, 64'h22); a3 = wd(0, 64'h23); a4 = wd(1, 64'h24);
    b1 = wd(0, 64'h31); b2 = wd(1, 64'h32); b3 = wd(0, 64'h33); b4 = wd(1, 64'h34);
    tbl.push_back(mkv(1,0,2'b11, 0,z, 0,z, 1, 0,0,0,z, 0,0));
    tbl.push_back(mkv(0,1,2'b11, 1,a1, 1,b1, 1, 0,0,0,z, 0,0));
    tbl.push_back(mkv(0,1,2'b11, 1,a1, 1,b1, 1, 1,0,0,z, 1,0));
    tbl.push_back(mkv(0,1,2'b11, 1,a2, 1,b1, 1, 1,0,1,a1, 1,0));
    tbl.push_back(mkv(0,1,2'b11, 1,a3, 1,b1, 1, 0,0,1,a2, 0,0));
    tbl.push_back(mkv(0,1,2'b11, 1,a3, 1,b1, 1, 0,1,0,a2, 1,1));
    tbl.push_back(mkv(0,1,2'b11, 1,a3, 1,b2, 1, 0,1,1,b1, 1,1));
    tbl.push_back(mkv(0,1,2'b11, 1,a3, 1,b3, 1, 0,0,1,b2, 0,1));
    tbl.push_back(mkv(0,1,2'b11, 1,a3, 1,b3, 1, 1,0,0,b2, 1,0));
    tbl.push_back(mkv(0,1,2'b11, 1,a4, 1,b3, 1, 1,0,1,a3, 1,0));
    tbl.push_back(mkv(0,1,2'b11, 0,z, 1,b3, 1, 0,0,1,a4, 0,0));
    tbl.push_back(mkv(0,1,2'b11, 0,z, 1,b3, 1, 0,1,0,a4, 1,1));
    tbl.push_back(mkv(0,1,2'b11, 0,z, 1,b4, 1, 0,1,1,b3, 1,1));
    tbl.push_back(mkv(0,1,2'b11, 0,z, 0,z, 1, 0,0,1,b4, 0,1));
    tbl.push_back(mkv(0,1,2'b11, 0,z, 0,z, 1, 0,0,0,b4, 0,1));
    // Single-word frame, then a disabled source that must not be granted.
    w41 = wd(1, 64'h41); w51 = wd(1, 64'h51);
    tbl.push_back(mkv(0,1,2'b11, 0,z, 1,w41, 1, 0,0,0,b4, 0,1));
    tbl.push_back(mkv(0,1,2'b11, 0,z, 1,w41, 1, 0,1,0,b4, 1,1));
    tbl.push_back(mkv(0,1,2'b11, 0,z, 0,z, 1, 0,0,1,w41, 0,1));
    tbl.push_back(mkv(0,1,2'b11, 0,z, 0,z, 1, 0,0,0,w41, 0,1));
    tbl.push_back(mkv(0,1,2'b10, 1,w51, 0,z, 1, 0,0,0,w41, 0,1));
    tbl.push_back(mkv(0,1,2'b10, 1,w51, 0,z, 1, 0,0,0,w41, 0,1));

    foreach (tbl[i]) begin
      @(posedge clk); #1;
      reset = tbl[i].rst;
      src_enable = tbl[i].en;
      drive_src(0, tbl[i].s0_req, tbl[i].s0_data);
      drive_src(1, tbl[i].s1_req, tbl[i].s1_data);
      ifc.TX_FIFO_pipe_write_ack = tbl[i].tx_ack;
      @(negedge clk);
      if (tbl[i].chk) begin
        check($sformatf("v%0d_s0_ack", i), 128'(ifc.src0_pipe_write_ack), 128'(tbl[i].e_s0_ack));
        check($sformatf("v%0d_s1_ack", i), 128'(ifc.src1_pipe_write_ack), 128'(tbl[i].e_s1_ack));
        check($sformatf("v%0d_tx_req", i), 128'(ifc.TX_FIFO_pipe_write_req), 128'(tbl[i].e_tx_req));
        check($sformatf("v%0d_tx_data", i), 128'(ifc.TX_FIFO_pipe_write_data), 128'(tbl[i].e_tx_data));
        check($sformatf("v%0d_busy", i), 128'(busy), 128'(tbl[i].e_busy));
        check($sformatf("v%0d_grant", i), 128'(grant_id), 128'(tbl[i].e_grant));
      end
    end

    // Downstream stall of 4 cycles mid-frame: held word stable, no ack, no loss.
    src_enable = 2'b11;
    ifc.TX_FIFO_pipe_write_ack = 1'b1;
    do_reset();
    exp_q.delete();
    sb_on = 1'b1;
    fork
      send_frame(0, 6, 64'h80);
      begin
        repeat (3) @(posedge clk);
        #1 ifc.TX_FIFO_pipe_write_ack = 1'b0;
        @(negedge clk);
        held = ifc.TX_FIFO_pipe_write_data;
        check("stall_tx_req", 128'(ifc.TX_FIFO_pipe_write_req), 128'(1));
        check("stall_s0_ack", 128'(ifc.src0_pipe_write_ack), 128'(0));
        repeat (3) begin
          @(negedge clk);
          check("stall_data_hold", 128'(ifc.TX_FIFO_pipe_write_data), 128'(held));
          check("stall_s0_ack_hold", 128'(ifc.src0_pipe_write_ack), 128'(0));
        end
        @(posedge clk); #1 ifc.TX_FIFO_pipe_write_ack = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1 check("stall_sb_drained", 128'(exp_q.size()), 128'(0));
`ifdef TX_ARB_STATS_EN
    check("stats_src0_one_frame", 128'(cnt0), 128'(1));
    check("stats_src1_zero", 128'(cnt1), 128'(0));
`endif

    // Enable 01 with both requesting; clear bit 0 mid-frame, frame still completes.
    src_enable = 2'b01;
    do_reset();
    exp_q.delete();
    s1_seen = 1'b0;
    drive_src(1, 1'b1, wd(1, 64'h99));
    fork
      send_frame(0, 3, 64'h60);
      begin
        n = 0;
        while (!ifc.src0_pipe_write_ack && n < 20) begin
          @(negedge clk); n++;
        end
        @(posedge clk); #1 src_enable = 2'b00;
      end
      begin
        repeat (12) begin
          @(negedge clk);
          if (ifc.src1_pipe_write_ack) s1_seen = 1'b1;
        end
      end
    join
    repeat (4) @(posedge clk);
    #1 check("en_sb_drained", 128'(exp_q.size()), 128'(0));
    check("en_src1_never_acked", 128'(s1_seen), 128'(0));
    drive_src(0, 1'b1, wd(1, 64'h77));
    repeat (4) begin
      @(negedge clk);
      check("en_off_busy", 128'(busy), 128'(0));
      check("en_off_s0_ack", 128'(ifc.src0_pipe_write_ack), 128'(0));
      @(posedge clk); #1;
    end
    drive_src(0, 1'b0, '0);
    drive_src(1, 1'b0, '0);
    sb_on = 1'b0;

    // Reset mid-frame with downstream stalled: partial frame discarded.
    src_enable = 2'b11;
    ifc.TX_FIFO_pipe_write_ack = 1'b0;
    do_reset();
    drive_src(0, 1'b1, wd(0, 64'h70));
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rstmid_tx_req_before", 128'(ifc.TX_FIFO_pipe_write_req), 128'(1));
    check("rstmid_busy_before", 128'(busy), 128'(1));
    @(posedge clk); #1;
    reset = 1'b1;
    drive_src(0, 1'b0, '0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rstmid_tx_req", 128'(ifc.TX_FIFO_pipe_write_req), 128'(0));
    check("rstmid_tx_data", 128'(ifc.TX_FIFO_pipe_write_data), 128'(0));
    check("rstmid_busy", 128'(busy), 128'(0));
    check("rstmid_grant", 128'(grant_id), 128'(0));
    check("rstmid_state", 128'(state_dbg), 128'(IDLE));
    check("rstmid_s0_ack", 128'(ifc.src0_pipe_write_ack), 128'(0));
`ifdef TX_ARB_STATS_EN
    check("rstmid_cnt0", 128'(cnt0), 128'(0));
    check("rstmid_cnt1", 128'(cnt1), 128'(0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
